// File: rtl/interface_hcsr04.sv
// HC-SR04 front end: fires the trigger, times the echo and converts its width to 3-digit BCD cm.
// Define HCSR04_TIMEOUT_EN to add the echo timeout and the erro state.
module interface_hcsr04 #(
  parameter int unsigned TRIGGER_CYCLES = 500,
  parameter int unsigned CYCLES_PER_CM  = 2941,
  parameter int unsigned TIMEOUT_CYCLES = 3000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic        pronto,
  output logic [11:0] medida,
  output logic        timeout,
  output logic [3:0]  db_estado
);

  localparam int unsigned CNT_MAX = (TRIGGER_CYCLES > CYCLES_PER_CM) ? TRIGGER_CYCLES : CYCLES_PER_CM;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIGGER_CYCLES - 1);
  localparam logic [CW-1:0] CM_LAST   = CW'(CYCLES_PER_CM - 1);

`ifdef HCSR04_TIMEOUT_EN
  typedef enum logic [3:0] {
    INICIAL = 4'd0, PREPARACAO = 4'd1, ENVIA_TRIGGER = 4'd2, ESPERA_ECHO = 4'd3,
    MEDE = 4'd4, ARMAZENA = 4'd5, FINAL_MEDIDA = 4'd6, ERRO = 4'd7
  } estado_t;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;
  logic          to_fim;
`else
  typedef enum logic [3:0] {
    INICIAL = 4'd0, PREPARACAO = 4'd1, ENVIA_TRIGGER = 4'd2, ESPERA_ECHO = 4'd3,
    MEDE = 4'd4, ARMAZENA = 4'd5, FINAL_MEDIDA = 4'd6
  } estado_t;
`endif

  estado_t        estado, estado_prox;
  logic           echo_m, echo_s;
  logic [CW-1:0]  conta;
  logic [11:0]    bcd;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h999) r = v;
    else if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
    else begin
      r[3:0] = '0;
      if (v[7:4] != 4'd9) r[7:4] = v[7:4] + 4'd1;
      else begin
        r[7:4]  = '0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= estado_prox;
  end

`ifdef HCSR04_TIMEOUT_EN
  assign to_fim = (to_cnt == TO_LAST);
`endif

  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIAL:       if (medir) estado_prox = PREPARACAO;
      PREPARACAO:    estado_prox = ENVIA_TRIGGER;
      ENVIA_TRIGGER: if (conta == TRIG_LAST) estado_prox = ESPERA_ECHO;
      ESPERA_ECHO: begin
        if (echo_s) estado_prox = MEDE;
`ifdef HCSR04_TIMEOUT_EN
        if (to_fim) estado_prox = ERRO;
`endif
      end
      MEDE: begin
        if (!echo_s) estado_prox = ARMAZENA;
`ifdef HCSR04_TIMEOUT_EN
        if (to_fim) estado_prox = ERRO;
`endif
      end
      ARMAZENA:      estado_prox = FINAL_MEDIDA;
      FINAL_MEDIDA:  estado_prox = INICIAL;
`ifdef HCSR04_TIMEOUT_EN
      ERRO:          estado_prox = INICIAL;
`endif
      default:       estado_prox = INICIAL;
    endcase
  end

  always_comb begin
    trigger = (estado == ENVIA_TRIGGER);
    pronto  = (estado == FINAL_MEDIDA);
`ifdef HCSR04_TIMEOUT_EN
    timeout = (estado == ERRO);
    if (estado == ERRO) pronto = 1'b1;
`endif
  end

`ifndef HCSR04_TIMEOUT_EN
  // Timeout parameter is kept so both builds share one parameter list.
  localparam logic TIMEOUT_TIE = 1'b0 && (TIMEOUT_CYCLES != 0);
  assign timeout = TIMEOUT_TIE;
`endif

  assign db_estado = estado;

  // The same counter times the trigger and divides the echo into centimetres.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conta  <= '0;
      bcd    <= '0;
      medida <= '0;
    end else begin
      case (estado)
        PREPARACAO: begin
          conta <= '0;
          bcd   <= '0;
        end
        ENVIA_TRIGGER: conta <= (conta == TRIG_LAST) ? '0 : conta + 1'b1;
        MEDE: begin
          if (conta == CM_LAST) begin
            conta <= '0;
            bcd   <= bcd_inc(bcd);
          end else begin
            conta <= conta + 1'b1;
          end
        end
        ARMAZENA: medida <= bcd;
`ifdef HCSR04_TIMEOUT_EN
        ERRO:     medida <= '1;
`endif
        default: ;
      endcase
    end
  end

`ifdef HCSR04_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                        to_cnt <= '0;
    else if (estado == PREPARACAO)                     to_cnt <= '0;
    else if (estado == ESPERA_ECHO || estado == MEDE)  to_cnt <= to_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_interface_hcsr04.sv
// Bench for interface_hcsr04: transaction-level timing model scheduled per cycle, checked every cycle.
// Define HCSR04_TIMEOUT_EN to also exercise the echo timeout.
module tb_interface_hcsr04;
  localparam int unsigned T   = 4;
  localparam int unsigned CPC = 3;
  localparam int unsigned TO  = 4000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        medir = 1'b0;
  logic        echo  = 1'b0;
  logic        trigger, pronto, timeout;
  logic [11:0] medida;
  logic [3:0]  db_estado;

  interface_hcsr04 #(.TRIGGER_CYCLES(T), .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .medir(medir), .echo(echo),
    .trigger(trigger), .pronto(pronto), .medida(medida),
    .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  bit          tr_map[int];
  logic [3:0]  st_map[int];
  logic [11:0] pr_map[int];
  bit          to_map[int];
  logic [11:0] exp_med = 12'h000;
  bit          chk_en = 1'b0;
  int          n_tests = 0, n_fail = 0;
  int          pronto_cnt = 0, trig_hi = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int w);
    int d;
    d = w / CPC;
    if (d > 999) d = 999;
    return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
  endfunction

  always @(negedge clock) begin
    if (pronto)  pronto_cnt <= pronto_cnt + 1;
    if (trigger) trig_hi <= trig_hi + 1;
  end

  always @(negedge clock) begin : cmp
    logic [3:0] es;
    if (reset && chk_en) begin
      es = st_map.exists(cyc) ? st_map[cyc] : 4'd0;
      if (pr_map.exists(cyc)) exp_med = pr_map[cyc];
      check("trigger",   {31'd0, trigger}, {31'd0, tr_map.exists(cyc)});
      check("pronto",    {31'd0, pronto},  {31'd0, pr_map.exists(cyc)});
      check("timeout",   {31'd0, timeout}, {31'd0, to_map.exists(cyc)});
      check("medida",    {20'd0, medida},  {20'd0, exp_med});
      check("db_estado", {28'd0, db_estado}, {28'd0, es});
    end
  end

  // Called at a falling edge while the DUT is idle; medir is sampled at the next rising edge.
  task automatic run_meas(input int w, input int d, input bit hold, input bit noise);
    int k, e, c, p;
    k = cyc; e = k + 2 + T; c = e + d; p = c + w + 4;
    medir = 1'b1;
    st_map[k+1] = 4'd1;
    for (int i = k + 2; i <= k + 1 + T; i++) begin tr_map[i] = 1'b1; st_map[i] = 4'd2; end
    for (int i = e; i <= c + 2; i++) st_map[i] = 4'd3;
    for (int i = c + 3; i <= c + w + 2; i++) st_map[i] = 4'd4;
    st_map[c+w+3] = 4'd5;
    st_map[p]     = 4'd6;
    pr_map[p]     = to_bcd(w);
    @(negedge clock);
    if (!hold) medir = 1'b0;
    while (cyc < c) begin
      if (noise && !hold) medir = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    echo = 1'b1;
    repeat (w) begin
      if (noise && !hold) medir = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    echo = 1'b0;
    if (!hold) medir = 1'b0;
    while (cyc < p + 1) @(negedge clock);
  endtask

`ifdef HCSR04_TIMEOUT_EN
  task automatic run_timeout();
    int k, e, p;
    k = cyc; e = k + 2 + T; p = e + TO;
    medir = 1'b1;
    st_map[k+1] = 4'd1;
    for (int i = k + 2; i <= k + 1 + T; i++) begin tr_map[i] = 1'b1; st_map[i] = 4'd2; end
    for (int i = e; i < p; i++) st_map[i] = 4'd3;
    st_map[p] = 4'd7;
    pr_map[p] = 12'hFFF;
    to_map[p] = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    while (cyc < p + 1) @(negedge clock);
  endtask
`endif

  initial begin
    int k, c, t0, pc0, w;
    repeat (3) @(negedge clock);
    check("rst_trigger", {31'd0, trigger}, 32'd0);
    check("rst_pronto",  {31'd0, pronto},  32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_medida",  {20'd0, medida},  32'h000);
    check("rst_estado",  {28'd0, db_estado}, 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clock);

    // Measurement interrupted by reset while in mede.
    k = cyc; c = k + 2 + T;
    medir = 1'b1;
    st_map[k+1] = 4'd1;
    for (int i = k + 2; i <= k + 1 + T; i++) begin tr_map[i] = 1'b1; st_map[i] = 4'd2; end
    for (int i = c; i <= c + 2; i++) st_map[i] = 4'd3;
    for (int i = c + 3; i <= c + 6; i++) st_map[i] = 4'd4;
    @(negedge clock);
    medir = 1'b0;
    while (cyc < c) @(negedge clock);
    echo = 1'b1;
    while (cyc < c + 6) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_estado",  {28'd0, db_estado}, 32'd0);
    check("midrst_trigger", {31'd0, trigger}, 32'd0);
    check("midrst_medida",  {20'd0, medida}, 32'h000);
    echo = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    t0 = trig_hi;
    run_meas(30, 0, 1'b0, 1'b0);
    check("lit_010", {20'd0, medida}, 32'h010);
    check("lit_trig_width", trig_hi - t0, T);
    run_meas(29, 2, 1'b0, 1'b0);
    check("lit_009", {20'd0, medida}, 32'h009);
    run_meas(369, 1, 1'b0, 1'b1);
    check("lit_123", {20'd0, medida}, 32'h123);
    run_meas(3010, 0, 1'b0, 1'b0);
    check("lit_999", {20'd0, medida}, 32'h999);
    run_meas(1, 3, 1'b0, 1'b0);
    check("lit_000", {20'd0, medida}, 32'h000);

    for (int i = 0; i < 12; i++) begin
      w = $urandom_range(1, 400);
      run_meas(w, $urandom_range(0, 5), 1'b0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    pc0 = pronto_cnt;
    run_meas(45, 0, 1'b1, 1'b0);
    run_meas(77, 1, 1'b0, 1'b1);
    repeat (20) @(negedge clock);
    check("held_pronto_count", pronto_cnt - pc0, 2);
    check("lit_025", {20'd0, medida}, 32'h025);

`ifdef HCSR04_TIMEOUT_EN
    run_timeout();
    check("lit_fff", {20'd0, medida}, 32'hFFF);
    run_meas(60, 0, 1'b0, 1'b0);
    check("lit_020", {20'd0, medida}, 32'h020);
`endif

    repeat (5) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
